// File: rtl/ddr_dm_stats_monitor.sv
// ----------------------------------------------------------------------------
// ddr_dm_stats_monitor
//
// Purpose:
//   Passive statistics monitor for one datamover channel (S2MM or MM2S) in the
//   DDR path. It taps the command, data and status AXI-Stream handshakes and
//   accumulates event counters for the DDR control register block. Nothing on
//   the handshakes is driven or altered; every input is observe-only.
//
// Handshake semantics (all three taps):
//   A transfer happens on a rising edge of mem_clk where valid and ready are
//   both 1. valid without ready, or ready without valid, is not a transfer and
//   is ignored. Only completed transfers are counted.
//
// Ports:
//   mem_clk            in   clock, all logic on the rising edge
//   mem_reset          in   synchronous active-high reset
//   clear              in   synchronous counter clear pulse (wins over events)
//   cmd_valid/ready    in   command handshake tap
//   cmd_data           in   command payload, BTT in [BTT_WIDTH-1:0]
//   data_valid/ready   in   data stream handshake tap
//   data_last          in   last beat of a packet
//   sts_valid/ready    in   status handshake tap
//   sts_data           in   [7] OKAY, [6] SLVERR, [5] DECERR, [4] INTERR, [3:0] tag
//   dm_error_in        in   datamover error level
//   cmd_counter        out  accepted commands
//   word_counter       out  accepted data beats
//   pkg_counter        out  accepted data beats carrying data_last
//   sts_counter        out  accepted statuses
//   sts_error_counter  out  accepted statuses reporting an error
//   length_counter     out  sum of commanded bytes-to-transfer
//   outstanding        out  commands issued minus statuses received
//   dm_error           out  sticky copy of dm_error_in
//   protocol_error     out  sticky: status underflow or outstanding overflow
//
// All outputs are registers; there is no combinational input-to-output path.
// Counters wrap modulo their width.
// ----------------------------------------------------------------------------
module ddr_dm_stats_monitor #(
    parameter int CMD_WIDTH   = 72,
    parameter int BTT_WIDTH   = 23,
    parameter int OUTST_WIDTH = 8
) (
    input  logic                   mem_clk,
    input  logic                   mem_reset,
    input  logic                   clear,

    input  logic                   cmd_valid,
    input  logic                   cmd_ready,
    input  logic [CMD_WIDTH-1:0]   cmd_data,

    input  logic                   data_valid,
    input  logic                   data_ready,
    input  logic                   data_last,

    input  logic                   sts_valid,
    input  logic                   sts_ready,
    input  logic [7:0]             sts_data,

    input  logic                   dm_error_in,

    output logic [31:0]            cmd_counter,
    output logic [31:0]            word_counter,
    output logic [31:0]            pkg_counter,
    output logic [31:0]            sts_counter,
    output logic [31:0]            sts_error_counter,
    output logic [47:0]            length_counter,
    output logic [OUTST_WIDTH-1:0] outstanding,
    output logic                   dm_error,
    output logic                   protocol_error
);

    localparam int LEN_WIDTH = 48;

    // ------------------------------------------------------------------------
    // Handshake events
    // ------------------------------------------------------------------------
    logic cmd_fire;
    logic word_fire;
    logic pkg_fire;
    logic sts_fire;
    logic sts_is_error;

    assign cmd_fire  = cmd_valid & cmd_ready;
    assign word_fire = data_valid & data_ready;
    assign pkg_fire  = word_fire & data_last;
    assign sts_fire  = sts_valid & sts_ready;

    // A status is an error when OKAY is missing or any error flag is raised.
    assign sts_is_error = ~sts_data[7] | (|sts_data[6:4]);

    // Command bits above the BTT field and the status tag carry no statistics.
    logic unused_inputs;
    assign unused_inputs = ^{cmd_data[CMD_WIDTH-1:BTT_WIDTH], sts_data[3:0]};

    logic [LEN_WIDTH-1:0] cmd_btt;
    assign cmd_btt = {{(LEN_WIDTH-BTT_WIDTH){1'b0}}, cmd_data[BTT_WIDTH-1:0]};

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [31:0]            cmd_cnt_q,     cmd_cnt_d;
    logic [31:0]            word_cnt_q,    word_cnt_d;
    logic [31:0]            pkg_cnt_q,     pkg_cnt_d;
    logic [31:0]            sts_cnt_q,     sts_cnt_d;
    logic [31:0]            sts_err_cnt_q, sts_err_cnt_d;
    logic [LEN_WIDTH-1:0]   len_cnt_q,     len_cnt_d;
    logic [OUTST_WIDTH-1:0] outst_q,       outst_d;
    logic                   dm_err_q,      dm_err_d;
    logic                   proto_err_q,   proto_err_d;

    // ------------------------------------------------------------------------
    // Event counters
    // ------------------------------------------------------------------------
    always_comb begin
        cmd_cnt_d     = cmd_cnt_q;
        word_cnt_d    = word_cnt_q;
        pkg_cnt_d     = pkg_cnt_q;
        sts_cnt_d     = sts_cnt_q;
        sts_err_cnt_d = sts_err_cnt_q;
        len_cnt_d     = len_cnt_q;

        if (cmd_fire) begin
            cmd_cnt_d = cmd_cnt_q + 32'd1;
            len_cnt_d = len_cnt_q + cmd_btt;
        end
        if (word_fire) begin
            word_cnt_d = word_cnt_q + 32'd1;
        end
        if (pkg_fire) begin
            pkg_cnt_d = pkg_cnt_q + 32'd1;
        end
        if (sts_fire) begin
            sts_cnt_d = sts_cnt_q + 32'd1;
            if (sts_is_error) begin
                sts_err_cnt_d = sts_err_cnt_q + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outstanding commands and sticky error flags
    //
    // A command and a status in the same cycle cancel. The outstanding count
    // saturates at both ends instead of wrapping, and hitting either end with
    // a one-sided event marks a protocol error.
    // ------------------------------------------------------------------------
    logic outst_full;
    logic outst_empty;
    logic outst_overflow;
    logic outst_underflow;

    assign outst_full      = &outst_q;
    assign outst_empty     = ~|outst_q;
    assign outst_overflow  = cmd_fire & ~sts_fire & outst_full;
    assign outst_underflow = sts_fire & ~cmd_fire & outst_empty;

    always_comb begin
        outst_d = outst_q;
        if (cmd_fire && !sts_fire && !outst_full) begin
            outst_d = outst_q + {{(OUTST_WIDTH-1){1'b0}}, 1'b1};
        end else if (sts_fire && !cmd_fire && !outst_empty) begin
            outst_d = outst_q - {{(OUTST_WIDTH-1){1'b0}}, 1'b1};
        end

        proto_err_d = proto_err_q | outst_overflow | outst_underflow;
        dm_err_d    = dm_err_q | dm_error_in;
    end

    // ------------------------------------------------------------------------
    // Registers: reset and clear both zero everything and drop the events of
    // that cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge mem_clk) begin
        if (mem_reset || clear) begin
            cmd_cnt_q     <= '0;
            word_cnt_q    <= '0;
            pkg_cnt_q     <= '0;
            sts_cnt_q     <= '0;
            sts_err_cnt_q <= '0;
            len_cnt_q     <= '0;
            outst_q       <= '0;
            dm_err_q      <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            cmd_cnt_q     <= cmd_cnt_d;
            word_cnt_q    <= word_cnt_d;
            pkg_cnt_q     <= pkg_cnt_d;
            sts_cnt_q     <= sts_cnt_d;
            sts_err_cnt_q <= sts_err_cnt_d;
            len_cnt_q     <= len_cnt_d;
            outst_q       <= outst_d;
            dm_err_q      <= dm_err_d;
            proto_err_q   <= proto_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cmd_counter       = cmd_cnt_q;
    assign word_counter      = word_cnt_q;
    assign pkg_counter       = pkg_cnt_q;
    assign sts_counter       = sts_cnt_q;
    assign sts_error_counter = sts_err_cnt_q;
    assign length_counter    = len_cnt_q;
    assign outstanding       = outst_q;
    assign dm_error          = dm_err_q;
    assign protocol_error    = proto_err_q;

endmodule

// File: tb/tb_ddr_dm_stats_monitor.sv
// ----------------------------------------------------------------------------
// tb_ddr_dm_stats_monitor
//
// Drives the command/data/status taps of ddr_dm_stats_monitor with directed
// sequences and random traffic, and compares every output after every edge
// against a behavioural model of the counting rules.
// ----------------------------------------------------------------------------
module tb_ddr_dm_stats_monitor;

    localparam int CMD_W   = 72;
    localparam int BTT_W   = 23;
    localparam int OUTST_W = 8;
    localparam int OUT_MAX = (1 << OUTST_W) - 1;
    localparam int SNAP_W  = 32 * 5 + 48 + OUTST_W + 2;

    // ------------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------------
    logic mem_clk = 1'b0;
    logic mem_reset;
    always #5 mem_clk = ~mem_clk;

    logic             clear;
    logic             cmd_valid, cmd_ready;
    logic [CMD_W-1:0] cmd_data;
    logic             data_valid, data_ready, data_last;
    logic             sts_valid, sts_ready;
    logic [7:0]       sts_data;
    logic             dm_error_in;

    logic [31:0]        cmd_counter, word_counter, pkg_counter;
    logic [31:0]        sts_counter, sts_error_counter;
    logic [47:0]        length_counter;
    logic [OUTST_W-1:0] outstanding;
    logic               dm_error, protocol_error;

    ddr_dm_stats_monitor #(
        .CMD_WIDTH   (CMD_W),
        .BTT_WIDTH   (BTT_W),
        .OUTST_WIDTH (OUTST_W)
    ) dut (
        .mem_clk           (mem_clk),
        .mem_reset         (mem_reset),
        .clear             (clear),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_data          (cmd_data),
        .data_valid        (data_valid),
        .data_ready        (data_ready),
        .data_last         (data_last),
        .sts_valid         (sts_valid),
        .sts_ready         (sts_ready),
        .sts_data          (sts_data),
        .dm_error_in       (dm_error_in),
        .cmd_counter       (cmd_counter),
        .word_counter      (word_counter),
        .pkg_counter       (pkg_counter),
        .sts_counter       (sts_counter),
        .sts_error_counter (sts_error_counter),
        .length_counter    (length_counter),
        .outstanding       (outstanding),
        .dm_error          (dm_error),
        .protocol_error    (protocol_error)
    );

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: plain arithmetic on event counts
    // ------------------------------------------------------------------------
    longint m_cmd, m_word, m_pkg, m_sts, m_sts_err, m_len;
    int     m_out;
    bit     m_dme, m_perr;

    logic [SNAP_W-1:0] exp_q[$];

    task automatic model_zero();
        m_cmd = 0; m_word = 0; m_pkg = 0; m_sts = 0; m_sts_err = 0; m_len = 0;
        m_out = 0; m_dme = 0; m_perr = 0;
    endtask

    task automatic model_step();
        bit c, s;
        logic [BTT_W-1:0] btt;
        if (mem_reset || clear) begin
            model_zero();
        end else begin
            c = cmd_valid && cmd_ready;
            s = sts_valid && sts_ready;
            btt = cmd_data[BTT_W-1:0];
            if (c) begin
                m_cmd = (m_cmd + 1) % (64'd1 << 32);
                m_len = (m_len + longint'(btt)) % (64'd1 << 48);
            end
            if (data_valid && data_ready) begin
                m_word = (m_word + 1) % (64'd1 << 32);
                if (data_last) m_pkg = (m_pkg + 1) % (64'd1 << 32);
            end
            if (s) begin
                m_sts = (m_sts + 1) % (64'd1 << 32);
                if (sts_data[7] == 1'b0 || sts_data[6:4] != 3'b000)
                    m_sts_err = (m_sts_err + 1) % (64'd1 << 32);
            end
            m_out = m_out + int'(c) - int'(s);
            if (m_out > OUT_MAX) begin
                m_out  = OUT_MAX;
                m_perr = 1;
            end
            if (m_out < 0) begin
                m_out  = 0;
                m_perr = 1;
            end
            if (dm_error_in) m_dme = 1;
        end
        exp_q.push_back({32'(m_cmd), 32'(m_word), 32'(m_pkg), 32'(m_sts),
                         32'(m_sts_err), 48'(m_len), OUTST_W'(m_out), m_dme, m_perr});
    endtask

    task automatic compare_outputs();
        logic [SNAP_W-1:0] e;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        check("cmd_counter",       64'(cmd_counter),       64'(e[SNAP_W-1    -: 32]));
        check("word_counter",      64'(word_counter),      64'(e[SNAP_W-33   -: 32]));
        check("pkg_counter",       64'(pkg_counter),       64'(e[SNAP_W-65   -: 32]));
        check("sts_counter",       64'(sts_counter),       64'(e[SNAP_W-97   -: 32]));
        check("sts_error_counter", 64'(sts_error_counter), 64'(e[SNAP_W-129  -: 32]));
        check("length_counter",    64'(length_counter),    64'(e[SNAP_W-161  -: 48]));
        check("outstanding",       64'(outstanding),       64'(e[OUTST_W+1   -: OUTST_W]));
        check("dm_error",          64'(dm_error),          64'(e[1]));
        check("protocol_error",    64'(protocol_error),    64'(e[0]));
    endtask

    // ------------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------------
    task automatic set_idle();
        clear = 0;
        cmd_valid = 0; cmd_ready = 0; cmd_data = '0;
        data_valid = 0; data_ready = 0; data_last = 0;
        sts_valid = 0; sts_ready = 0; sts_data = '0;
        dm_error_in = 0;
    endtask

    // One clock: inputs already set, model follows the edge, outputs sampled 1ns later.
    task automatic tick();
        @(posedge mem_clk);
        model_step();
        #1;
        compare_outputs();
    endtask

    function automatic logic [CMD_W-1:0] make_cmd(input logic [BTT_W-1:0] btt);
        logic [CMD_W-1:0] v;
        v = {8'($urandom), $urandom, $urandom};
        v[BTT_W-1:0] = btt;
        return v;
    endfunction

    task automatic send_cmd(input logic [BTT_W-1:0] btt);
        set_idle();
        cmd_valid = 1; cmd_ready = 1; cmd_data = make_cmd(btt);
        tick();
    endtask

    task automatic send_beat(input logic last);
        set_idle();
        data_valid = 1; data_ready = 1; data_last = last;
        tick();
    endtask

    task automatic send_sts(input logic [7:0] s);
        set_idle();
        sts_valid = 1; sts_ready = 1; sts_data = s;
        tick();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            set_idle();
            tick();
        end
    endtask

    task automatic do_clear();
        set_idle();
        clear = 1;
        tick();
    endtask

    task automatic random_inputs(input int clr_pct);
        cmd_valid  = ($urandom_range(0, 99) < 60);
        cmd_ready  = ($urandom_range(0, 99) < 70);
        cmd_data   = {8'($urandom), $urandom, $urandom};
        data_valid = ($urandom_range(0, 99) < 70);
        data_ready = ($urandom_range(0, 99) < 70);
        data_last  = ($urandom_range(0, 3) == 0);
        sts_valid  = ($urandom_range(0, 99) < 55);
        sts_ready  = ($urandom_range(0, 99) < 70);
        sts_data   = ($urandom_range(0, 1) == 0) ? 8'h80 : 8'($urandom);
        dm_error_in = ($urandom_range(0, 199) == 0);
        clear      = ($urandom_range(0, 99) < clr_pct);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        model_zero();
        set_idle();
        mem_reset = 1;

        // Reset with everything toggling: outputs stay 0.
        for (int i = 0; i < 6; i++) begin
            random_inputs(0);
            tick();
            check("reset_cmd_counter", 64'(cmd_counter), 64'd0);
        end
        mem_reset = 0;

        // First command after release counts one cycle later.
        send_cmd(23'h40);
        check("first_cmd", 64'(cmd_counter), 64'd1);
        send_cmd(23'h7FFFFF);
        send_cmd(23'h1);
        for (int i = 0; i < 4; i++) send_beat(i == 3);
        check("tp_cmd3",   64'(cmd_counter),    64'd3);
        check("tp_len",    64'(length_counter), 64'h800040);
        check("tp_words",  64'(word_counter),   64'd4);
        check("tp_pkgs",   64'(pkg_counter),    64'd1);

        // Statuses: OKAY, OKAY+SLVERR, nothing.
        send_sts(8'h80);
        send_sts(8'hC0);
        send_sts(8'h00);
        check("tp_sts",     64'(sts_counter),       64'd3);
        check("tp_sts_err", 64'(sts_error_counter), 64'd2);
        check("tp_outst0",  64'(outstanding),       64'd0);
        check("tp_perr0",   64'(protocol_error),    64'd0);

        // Simultaneous command and status cancel.
        for (int i = 0; i < 5; i++) send_cmd(23'($urandom));
        set_idle();
        cmd_valid = 1; cmd_ready = 1; cmd_data = make_cmd(23'h10);
        sts_valid = 1; sts_ready = 1; sts_data = 8'h80;
        tick();
        check("both_outst5", 64'(outstanding), 64'd5);
        for (int i = 0; i < 5; i++) send_sts(8'h80);
        send_sts(8'h80);
        check("underflow_outst", 64'(outstanding),    64'd0);
        check("underflow_perr",  64'(protocol_error), 64'd1);

        // Valid without ready (and vice versa) is not a transfer.
        set_idle();
        cmd_valid = 1; data_ready = 1; sts_valid = 1; data_last = 1;
        tick();

        // Sticky dm_error, then clear colliding with a command.
        do_clear();
        set_idle();
        dm_error_in = 1;
        tick();
        idle_cycles(3);
        check("dm_error_held", 64'(dm_error), 64'd1);
        set_idle();
        clear = 1; cmd_valid = 1; cmd_ready = 1; cmd_data = make_cmd(23'h55);
        tick();
        check("clear_cmd0",  64'(cmd_counter), 64'd0);
        check("clear_dme0",  64'(dm_error),    64'd0);

        // Outstanding overflow.
        for (int i = 0; i < 256; i++) send_cmd(23'($urandom));
        check("overflow_outst", 64'(outstanding),    64'(OUT_MAX));
        check("overflow_perr",  64'(protocol_error), 64'd1);
        check("overflow_cmds",  64'(cmd_counter),    64'd256);

        // Random traffic with occasional clear and reset.
        do_clear();
        for (int i = 0; i < 3000; i++) begin
            random_inputs(1);
            mem_reset = ($urandom_range(0, 999) == 0);
            tick();
        end
        mem_reset = 0;
        set_idle();
        idle_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
